// File: rtl/vga_text_writer.sv
// vga_text_writer: turns an ASCII byte stream into VGA text-mode bus writes, tracking a cursor.
// Define VGA_TEXT_WRITER_COLOR_EN to also write the colour map from attr_i.
module vga_text_writer #(
    parameter int unsigned COLS      = 80,
    parameter int unsigned ROWS      = 30,
    parameter logic [31:0] BASE_ADDR = 32'h0700_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        char_valid_i,
    input  logic [7:0]  char_data_i,
    input  logic [7:0]  attr_i,
    output logic        char_ready_o,
    output logic        busy_o,
    output logic [6:0]  cursor_col_o,
    output logic [4:0]  cursor_row_o,
    output logic        req_o,
    output logic        we_o,
    output logic [3:0]  be_o,
    output logic [31:0] addr_o,
    output logic [31:0] wdata_o
);
    localparam int unsigned WORDS   = COLS * ROWS / 4;
    localparam logic [31:0] COL_OFS = 32'h0000_1000;
    localparam logic [31:0] BLANKS  = 32'h2020_2020;

    typedef enum logic [2:0] {IDLE, WR_CHAR, WR_COL, CLR_CHAR, CLR_COL} state_e;

    state_e      state_q, state_d;
    logic [6:0]  col_q, col_d;
    logic [4:0]  row_q, row_d;
    logic [9:0]  cnt_q, cnt_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        req_q, req_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    logic        accept;
    logic [11:0] pos;
    logic [31:0] char_addr;
    logic [3:0]  pos_be;
    logic [6:0]  adv_col;
    logic [4:0]  adv_row;
    logic [4:0]  nl_row;

`ifdef VGA_TEXT_WRITER_COLOR_EN
    logic [7:0]  attr_q, attr_d;
`else
    logic        unused_attr;
    assign unused_attr = ^attr_i;
`endif

    assign accept    = char_valid_i & ready_q;
    assign pos       = 12'(32'(row_q) * COLS + 32'(col_q));
    assign char_addr = BASE_ADDR + {20'd0, pos[11:2], 2'b00};
    assign pos_be    = 4'b0001 << pos[1:0];
    assign nl_row    = (row_q == 5'(ROWS - 1)) ? 5'd0 : row_q + 5'd1;
    assign adv_col   = (col_q == 7'(COLS - 1)) ? 7'd0 : col_q + 7'd1;
    assign adv_row   = (col_q == 7'(COLS - 1)) ? nl_row : row_q;

    // Bus outputs are registered, so each branch loads the values for the state being entered.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        ready_d = 1'b0;
        req_d   = 1'b0;
        be_d    = '0;
        addr_d  = '0;
        wdata_d = '0;
`ifdef VGA_TEXT_WRITER_COLOR_EN
        attr_d  = attr_q;
`endif
        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (accept) begin
                    if (char_data_i >= 8'h20 && char_data_i <= 8'h7E) begin
                        state_d = WR_CHAR;
                        ready_d = 1'b0;
                        req_d   = 1'b1;
                        be_d    = pos_be;
                        addr_d  = char_addr;
                        wdata_d = {4{char_data_i}};
`ifdef VGA_TEXT_WRITER_COLOR_EN
                        attr_d  = attr_i;
`endif
                    end else begin
                        case (char_data_i)
                            8'h0D: col_d = '0;
                            8'h0A: begin
                                col_d = '0;
                                row_d = nl_row;
                            end
                            8'h08: if (col_q != '0) col_d = col_q - 7'd1;
                            8'h0C: begin
                                state_d = CLR_CHAR;
                                ready_d = 1'b0;
                                cnt_d   = '0;
                                req_d   = 1'b1;
                                be_d    = '1;
                                addr_d  = BASE_ADDR;
                                wdata_d = BLANKS;
`ifdef VGA_TEXT_WRITER_COLOR_EN
                                attr_d  = attr_i;
`endif
                            end
                            default: ;
                        endcase
                    end
                end
            end
            WR_CHAR: begin
`ifdef VGA_TEXT_WRITER_COLOR_EN
                state_d = WR_COL;
                req_d   = 1'b1;
                be_d    = pos_be;
                addr_d  = char_addr + COL_OFS;
                wdata_d = {4{attr_q}};
`else
                state_d = IDLE;
                ready_d = 1'b1;
                col_d   = adv_col;
                row_d   = adv_row;
`endif
            end
`ifdef VGA_TEXT_WRITER_COLOR_EN
            WR_COL: begin
                state_d = IDLE;
                ready_d = 1'b1;
                col_d   = adv_col;
                row_d   = adv_row;
            end
`endif
            CLR_CHAR: begin
                if (cnt_q != 10'(WORDS - 1)) begin
                    cnt_d   = cnt_q + 10'd1;
                    req_d   = 1'b1;
                    be_d    = '1;
                    addr_d  = BASE_ADDR + 32'({cnt_d, 2'b00});
                    wdata_d = BLANKS;
                end else begin
`ifdef VGA_TEXT_WRITER_COLOR_EN
                    state_d = CLR_COL;
                    cnt_d   = '0;
                    req_d   = 1'b1;
                    be_d    = '1;
                    addr_d  = BASE_ADDR + COL_OFS;
                    wdata_d = {4{attr_q}};
`else
                    state_d = IDLE;
                    ready_d = 1'b1;
                    col_d   = '0;
                    row_d   = '0;
`endif
                end
            end
`ifdef VGA_TEXT_WRITER_COLOR_EN
            CLR_COL: begin
                if (cnt_q != 10'(WORDS - 1)) begin
                    cnt_d   = cnt_q + 10'd1;
                    req_d   = 1'b1;
                    be_d    = '1;
                    addr_d  = BASE_ADDR + COL_OFS + 32'({cnt_d, 2'b00});
                    wdata_d = {4{attr_q}};
                end else begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            req_q   <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef VGA_TEXT_WRITER_COLOR_EN
            attr_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            req_q   <= req_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifdef VGA_TEXT_WRITER_COLOR_EN
            attr_q  <= attr_d;
`endif
        end
    end

    assign char_ready_o = ready_q;
    assign busy_o       = busy_q;
    assign cursor_col_o = col_q;
    assign cursor_row_o = row_q;
    assign req_o        = req_q;
    assign we_o         = req_q;
    assign be_o         = be_q;
    assign addr_o       = addr_q;
    assign wdata_o      = wdata_q;

endmodule

// File: tb/tb_vga_text_writer.sv
// Self-checking bench for vga_text_writer: bus writes checked through an expectation queue,
// cursor/handshake behaviour through a vector table and a few timed sequences.
module tb_vga_text_writer;
    localparam logic [31:0] BASE = 32'h0700_0000;
`ifdef VGA_TEXT_WRITER_COLOR_EN
    localparam bit COLOR = 1'b1;
`else
    localparam bit COLOR = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_t;

    typedef struct {
        logic [7:0] b;
        logic [6:0] col;
        logic [4:0] row;
        logic       rdy;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        char_valid_i;
    logic [7:0]  char_data_i;
    logic [7:0]  attr_i;
    logic        char_ready_o, busy_o, req_o, we_o;
    logic [6:0]  cursor_col_o;
    logic [4:0]  cursor_row_o;
    logic [3:0]  be_o;
    logic [31:0] addr_o, wdata_o;

    int   errors = 0;
    int   checks = 0;
    bus_t exp_q[$];
    bus_t mon_e;
    int   mcol = 0;
    int   mrow = 0;
    logic post_ready, post_req;

    vga_text_writer dut (
        .clk_i(clk), .rst_ni(rst_ni), .char_valid_i(char_valid_i), .char_data_i(char_data_i),
        .attr_i(attr_i), .char_ready_o(char_ready_o), .busy_o(busy_o),
        .cursor_col_o(cursor_col_o), .cursor_row_o(cursor_row_o), .req_o(req_o), .we_o(we_o),
        .be_o(be_o), .addr_o(addr_o), .wdata_o(wdata_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [95:0] all_outs();
        return {12'd0, char_ready_o, busy_o, cursor_col_o, cursor_row_o, req_o, we_o, be_o, addr_o, wdata_o};
    endfunction

    always @(negedge clk) begin
        if (rst_ni) begin
            if (req_o || we_o) check("we_eq_req", we_o, req_o);
            if (req_o) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL bus_unexpected: got addr=%h be=%b wdata=%h expected no request", addr_o, be_o, wdata_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("bus_write", {addr_o, be_o, wdata_o}, {mon_e.addr, mon_e.be, mon_e.wdata});
                end
            end
        end
    end

    task automatic push(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        bus_t t;
        t.addr = a; t.be = be; t.wdata = d;
        exp_q.push_back(t);
    endtask

    task automatic model_accept(input logic [7:0] b, input logic [7:0] a);
        int p;
        if (b >= 8'h20 && b <= 8'h7E) begin
            p = mrow * 80 + mcol;
            push(BASE + 32'(p - p % 4), 4'b0001 << (p % 4), {4{b}});
            if (COLOR) push(BASE + 32'h1000 + 32'(p - p % 4), 4'b0001 << (p % 4), {4{a}});
            if (mcol == 79) begin
                mcol = 0;
                mrow = (mrow == 29) ? 0 : mrow + 1;
            end else mcol++;
        end else begin
            case (b)
                8'h0D: mcol = 0;
                8'h0A: begin mcol = 0; mrow = (mrow == 29) ? 0 : mrow + 1; end
                8'h08: if (mcol > 0) mcol--;
                8'h0C: begin
                    for (int k = 0; k < 600; k++) push(BASE + 32'(4 * k), 4'hF, 32'h2020_2020);
                    if (COLOR) for (int k = 0; k < 600; k++) push(BASE + 32'h1000 + 32'(4 * k), 4'hF, {4{a}});
                    mcol = 0;
                    mrow = 0;
                end
                default: ;
            endcase
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic [7:0] a, input bit auto_model);
        int n = 0;
        @(negedge clk);
        while (!char_ready_o && n < 5000) begin @(negedge clk); n++; end
        if (!char_ready_o) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got ready=0 expected ready=1 within 5000 cycles");
            return;
        end
        char_valid_i = 1'b1;
        char_data_i  = b;
        attr_i       = a;
        if (auto_model) model_accept(b, a);
        @(posedge clk);
        #1 char_valid_i = 1'b0;
        @(negedge clk);
        post_ready = char_ready_o;
        post_req   = req_o;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(char_ready_o && !busy_o) && n < 5000) begin @(negedge clk); n++; end
        if (!(char_ready_o && !busy_o)) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy=%b ready=%b expected idle", busy_o, char_ready_o);
        end
    endtask

    task automatic check_cursor(input string name, input logic [6:0] c, input logic [4:0] r);
        check(name, {cursor_col_o, cursor_row_o}, {c, r});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        vec_t tbl[11];
        logic [7:0] str[5];
        int acc[5];
        int idx, cyc, lim, n;

        tbl[0]  = '{8'h0A, 7'd0, 5'd3, 1'b1};
        tbl[1]  = '{8'h08, 7'd0, 5'd3, 1'b1};
        tbl[2]  = '{8'h07, 7'd0, 5'd3, 1'b1};
        tbl[3]  = '{8'h41, 7'd1, 5'd3, 1'b0};
        tbl[4]  = '{8'h42, 7'd2, 5'd3, 1'b0};
        tbl[5]  = '{8'h08, 7'd1, 5'd3, 1'b1};
        tbl[6]  = '{8'h0D, 7'd0, 5'd3, 1'b1};
        tbl[7]  = '{8'h7E, 7'd1, 5'd3, 1'b0};
        tbl[8]  = '{8'h7F, 7'd1, 5'd3, 1'b1};
        tbl[9]  = '{8'h1F, 7'd1, 5'd3, 1'b1};
        tbl[10] = '{8'h20, 7'd2, 5'd3, 1'b0};
        str = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};

        rst_ni = 1'b0;
        char_valid_i = 1'b0;
        char_data_i = '0;
        attr_i = '0;
        #1 check("reset_outputs", all_outs(), 96'd0);
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;
        check("ready_before_first_edge", char_ready_o, 1'b0);
        @(negedge clk);
        check("ready_after_release", {char_ready_o, busy_o, req_o}, 3'b100);
        check_cursor("cursor_reset", 7'd0, 5'd0);

        // 'A' with attribute 0x1F: explicit expectations and exact latency
        push(BASE, 4'b0001, 32'h4141_4141);
        if (COLOR) push(BASE + 32'h1000, 4'b0001, 32'h1F1F_1F1F);
        send_byte(8'h41, 8'h1F, 1'b0);
        mcol = 1;
        check("t1_first_cycle", {post_req, post_ready}, 2'b10);
        n = 1;
        while (!char_ready_o && n < 20) begin @(negedge clk); n++; end
        check("t1_ready_latency", n, COLOR ? 3 : 2);
        check_cursor("t1_cursor", 7'd1, 5'd0);

        // "ABCDE" streamed with valid held high
        send_byte(8'h0D, 8'h00, 1'b1);
        wait_idle();
        idx = 0; cyc = 0; lim = 0;
        char_valid_i = 1'b1;
        char_data_i = str[0];
        attr_i = 8'h2A;
        while (idx < 5 && lim < 100) begin
            if (char_ready_o) begin
                acc[idx] = cyc;
                model_accept(str[idx], 8'h2A);
                idx++;
                @(posedge clk);
                #1;
                if (idx < 5) char_data_i = str[idx];
                else char_valid_i = 1'b0;
            end
            @(negedge clk);
            cyc++;
            lim++;
        end
        char_valid_i = 1'b0;
        check("t2_all_accepted", idx, 5);
        for (int i = 1; i < 5; i++)
            check($sformatf("t2_accept_spacing%0d", i), acc[i] - acc[i-1], COLOR ? 3 : 2);
        wait_idle();
        check_cursor("t2_cursor", 7'd5, 5'd0);

        // Walk to (79,29), then 'Z' wraps the cursor to (0,0)
        send_byte(8'h0D, 8'h00, 1'b1);
        for (int i = 0; i < 29; i++) send_byte(8'h0A, 8'h00, 1'b1);
        for (int i = 0; i < 79; i++) send_byte(8'h30 + 8'(i % 40), 8'h1E, 1'b1);
        wait_idle();
        check_cursor("t3_cursor_corner", 7'd79, 5'd29);
        push(BASE + 32'h95C, 4'b1000, 32'h5A5A_5A5A);
        if (COLOR) push(BASE + 32'h195C, 4'b1000, 32'h4E4E_4E4E);
        send_byte(8'h5A, 8'h4E, 1'b0);
        mcol = 0; mrow = 0;
        wait_idle();
        check_cursor("t3_cursor_wrap", 7'd0, 5'd0);

        // Line feed wraps the last row to row 0
        for (int i = 0; i < 29; i++) send_byte(8'h0A, 8'h00, 1'b1);
        check_cursor("lf_row29", 7'd0, 5'd29);
        send_byte(8'h0A, 8'h00, 1'b1);
        check_cursor("lf_wrap", 7'd0, 5'd0);

        // Move to (5,2), then apply the vector table
        send_byte(8'h0A, 8'h00, 1'b1);
        send_byte(8'h0A, 8'h00, 1'b1);
        for (int i = 0; i < 5; i++) send_byte(8'h61 + 8'(i), 8'h17, 1'b1);
        wait_idle();
        check_cursor("t4_start", 7'd5, 5'd2);
        for (int i = 0; i < 11; i++) begin
            send_byte(tbl[i].b, 8'h3C, 1'b1);
            check($sformatf("tbl%0d_ready", i), post_ready, tbl[i].rdy);
            check($sformatf("tbl%0d_req", i), post_req, !tbl[i].rdy);
            wait_idle();
            check_cursor($sformatf("tbl%0d_cursor", i), tbl[i].col, tbl[i].row);
        end

        // Form feed: full clear with attribute 0x07
        send_byte(8'h0C, 8'h07, 1'b1);
        check("t5_ready_low", post_ready, 1'b0);
        n = 0;
        while (busy_o && n < 3000) begin n++; @(negedge clk); end
        check("t5_busy_cycles", n, COLOR ? 1200 : 600);
        check("t5_queue_empty", exp_q.size(), 0);
        check_cursor("t5_cursor", 7'd0, 5'd0);

        // Reset in the middle of a clear
        send_byte(8'h0C, 8'h55, 1'b1);
        n = 0;
        while (!(req_o && addr_o == BASE + 32'd400) && n < 1000) begin @(negedge clk); n++; end
        check("t6_reached_word100", addr_o, BASE + 32'd400);
        #2 rst_ni = 1'b0;
        #1 check("t6_outputs_in_reset", all_outs(), 96'd0);
        exp_q.delete();
        mcol = 0; mrow = 0;
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        check("t6_after_release", {char_ready_o, busy_o, req_o}, 3'b100);
        n = 0;
        repeat (20) begin @(negedge clk); if (req_o) n++; end
        check("t6_no_resume", n, 0);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
